host_cmd_master: RTL and testbench

Host-side command initiator for the configurable multi-clock system: the requesting end of the command/response byte protocol that the system controller serves. It accepts one high-level request (register write, register read, ALU with operands, ALU without operands) and serialises it into opcode and argument bytes on a UART-TX byte interface. For requests that produce a response, it collects the response bytes from a UART-RX byte interface and returns the assembled result with a timeout error flag. It is used as a bring-up/self-test master and as the bench-side driver of the system.

---
 rtl/host_cmd_master_pkg.sv | 59 +++++
 rtl/host_cmd_master_if.sv | 37 +++
 rtl/host_cmd_master.sv | 275 +++++++++++++++++++++++++++
 tb/tb_host_cmd_master.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_cmd_master_pkg.sv
// Shared constants and types for the host command master: protocol opcodes,
// command/state enums and per-command frame/response lengths.
package host_cmd_pkg;

  localparam logic [7:0] RF_WR   = 8'hAA;
  localparam logic [7:0] RF_RD   = 8'hBB;
  localparam logic [7:0] ALU_OP  = 8'hCC;
  localparam logic [7:0] ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CMD_RF_WR   = 2'd0,
    CMD_RF_RD   = 2'd1,
    CMD_ALU_OP  = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_RECV    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [2:0] TX_LEN_RF_WR   = 3'd3;
  localparam logic [2:0] TX_LEN_RF_RD   = 3'd2;
  localparam logic [2:0] TX_LEN_ALU_OP  = 3'd4;
  localparam logic [2:0] TX_LEN_ALU_NOP = 3'd2;

  localparam logic [1:0] RX_LEN_RF_WR   = 2'd0;
  localparam logic [1:0] RX_LEN_RF_RD   = 2'd1;
  localparam logic [1:0] RX_LEN_ALU_OP  = 2'd2;
  localparam logic [1:0] RX_LEN_ALU_NOP = 2'd2;

  // Index of the last frame byte; a 4-byte frame wraps to 2'd3 in two bits.
  function automatic logic [1:0] tx_last_idx(input cmd_type_e t);
    logic [2:0] len;
    case (t)
      CMD_RF_WR:  len = TX_LEN_RF_WR;
      CMD_RF_RD:  len = TX_LEN_RF_RD;
      CMD_ALU_OP: len = TX_LEN_ALU_OP;
      default:    len = TX_LEN_ALU_NOP;
    endcase
    tx_last_idx = len[1:0] - 2'd1;
  endfunction

  function automatic logic rx_last_idx(input cmd_type_e t);
    logic [1:0] len;
    case (t)
      CMD_RF_WR:  len = RX_LEN_RF_WR;
      CMD_RF_RD:  len = RX_LEN_RF_RD;
      CMD_ALU_OP: len = RX_LEN_ALU_OP;
      default:    len = RX_LEN_ALU_NOP;
    endcase
    rx_last_idx = len[1];
  endfunction

endpackage

// File: rtl/host_cmd_master_if.sv
// Request, UART byte and response signals of the host command master,
// with the master (design) and slave (driver/bench) views.
interface host_cmd_master_if #(
  parameter int BusWidth  = 8,
  parameter int AddWidth  = 4,
  parameter int FuncWidth = 4
);

  logic                  Cmd_Valid;
  logic                  Cmd_Ready;
  logic [1:0]            Cmd_Type;
  logic [AddWidth-1:0]   Cmd_Addr;
  logic [BusWidth-1:0]   Cmd_OpA;
  logic [BusWidth-1:0]   Cmd_OpB;
  logic [FuncWidth-1:0]  Cmd_Fun;
  logic [BusWidth-1:0]   TX_P_Data;
  logic                  TX_D_VLD;
  logic                  TX_Busy;
  logic [BusWidth-1:0]   RX_P_Data;
  logic                  RX_D_VLD;
  logic                  Rsp_Valid;
  logic [2*BusWidth-1:0] Rsp_Data;
  logic                  Rsp_Error;

  modport master (
    input  Cmd_Valid, Cmd_Type, Cmd_Addr, Cmd_OpA, Cmd_OpB, Cmd_Fun,
    input  TX_Busy, RX_P_Data, RX_D_VLD,
    output Cmd_Ready, TX_P_Data, TX_D_VLD, Rsp_Valid, Rsp_Data, Rsp_Error
  );

  modport slave (
    output Cmd_Valid, Cmd_Type, Cmd_Addr, Cmd_OpA, Cmd_OpB, Cmd_Fun,
    output TX_Busy, RX_P_Data, RX_D_VLD,
    input  Cmd_Ready, TX_P_Data, TX_D_VLD, Rsp_Valid, Rsp_Data, Rsp_Error
  );

endinterface

// File: rtl/host_cmd_master.sv
// Host command initiator: serialises one request into opcode/argument bytes on
// the UART-TX byte port and assembles the response bytes from UART-RX.
module host_cmd_master
  import host_cmd_pkg::*;
#(
  parameter int BusWidth     = 8,
  parameter int AddWidth     = 4,
  parameter int FuncWidth    = 4,
  parameter int TimeoutWidth = 16
) (
  input  logic               CLK,
  input  logic               RST,
  host_cmd_master_if.master  bus
);

  localparam logic [TimeoutWidth-1:0] TMO_MAX = {TimeoutWidth{1'b1}};

  state_e                 state_r;
  state_e                 state_next_s;
  cmd_type_e              type_r;
  logic [AddWidth-1:0]    addr_r;
  logic [BusWidth-1:0]    opa_r;
  logic [BusWidth-1:0]    opb_r;
  logic [FuncWidth-1:0]   fun_r;
  logic [1:0]             tx_idx_r;
  logic                   rx_cnt_r;
  logic [TimeoutWidth-1:0] tmo_r;
  logic                   rx_prev_r;
  logic [BusWidth-1:0]    byte0_r;
  logic [BusWidth-1:0]    byte1_r;
  logic [BusWidth-1:0]    tx_data_r;
  logic                   tx_vld_r;
  logic                   cmd_ready_r;
  logic                   rsp_valid_r;
  logic [2*BusWidth-1:0]  rsp_data_r;
  logic                   rsp_error_r;

  logic                   accept_s;
  logic                   tx_strobe_s;
  logic                   tx_inc_s;
  logic                   tmo_clr_s;
  logic                   capture_s;
  logic                   tmo_err_s;
  logic                   rx_edge_s;
  logic [1:0]             tx_last_s;
  logic                   rx_last_s;
  logic [BusWidth-1:0]    addr_ext_s;
  logic [BusWidth-1:0]    fun_ext_s;
  logic [BusWidth-1:0]    tx_byte_s;
  logic [BusWidth-1:0]    byte0_next_s;
  logic [BusWidth-1:0]    byte1_next_s;
  logic [2*BusWidth-1:0]  rsp_data_s;

  assign rx_edge_s  = bus.RX_D_VLD & ~rx_prev_r;
  assign tx_last_s  = tx_last_idx(type_r);
  assign rx_last_s  = rx_last_idx(type_r);
  assign addr_ext_s = {{(BusWidth-AddWidth){1'b0}}, addr_r};
  assign fun_ext_s  = {{(BusWidth-FuncWidth){1'b0}}, fun_r};

  assign bus.Cmd_Ready = cmd_ready_r;
  assign bus.TX_P_Data = tx_data_r;
  assign bus.TX_D_VLD  = tx_vld_r;
  assign bus.Rsp_Valid = rsp_valid_r;
  assign bus.Rsp_Data  = rsp_data_r;
  assign bus.Rsp_Error = rsp_error_r;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    tx_strobe_s  = 1'b0;
    tx_inc_s     = 1'b0;
    tmo_clr_s    = 1'b0;
    capture_s    = 1'b0;
    tmo_err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.Cmd_Valid) begin
          accept_s     = 1'b1;
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (!bus.TX_Busy) begin
          tx_strobe_s  = 1'b1;
          state_next_s = ST_WAIT_HI;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_WAIT_HI: begin
        if (bus.TX_Busy) begin
          state_next_s = ST_WAIT_LO;
        end else begin
          state_next_s = ST_WAIT_HI;
        end
      end
      ST_WAIT_LO: begin
        if (!bus.TX_Busy) begin
          if (tx_idx_r != tx_last_s) begin
            tx_inc_s     = 1'b1;
            state_next_s = ST_LOAD;
          end else if (type_r == CMD_RF_WR) begin
            state_next_s = ST_DONE;
          end else begin
            tmo_clr_s    = 1'b1;
            state_next_s = ST_RECV;
          end
        end else begin
          state_next_s = ST_WAIT_LO;
        end
      end
      ST_RECV: begin
        // A byte arriving on the timeout cycle still counts.
        if (rx_edge_s) begin
          capture_s = 1'b1;
          if (rx_cnt_r == rx_last_s) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_RECV;
          end
        end else if (tmo_r == TMO_MAX) begin
          tmo_err_s    = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RECV;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Byte mux selecting the frame byte for the current index and command type.
  always_comb begin
    tx_byte_s = {BusWidth{1'b0}};
    case (tx_idx_r)
      2'd0: begin
        case (type_r)
          CMD_RF_WR:  tx_byte_s = BusWidth'(RF_WR);
          CMD_RF_RD:  tx_byte_s = BusWidth'(RF_RD);
          CMD_ALU_OP: tx_byte_s = BusWidth'(ALU_OP);
          default:    tx_byte_s = BusWidth'(ALU_NOP);
        endcase
      end
      2'd1: begin
        if (type_r == CMD_ALU_OP) begin
          tx_byte_s = opa_r;
        end else if (type_r == CMD_ALU_NOP) begin
          tx_byte_s = fun_ext_s;
        end else begin
          tx_byte_s = addr_ext_s;
        end
      end
      2'd2: begin
        if (type_r == CMD_RF_WR) begin
          tx_byte_s = opa_r;
        end else if (type_r == CMD_ALU_OP) begin
          tx_byte_s = opb_r;
        end else begin
          tx_byte_s = {BusWidth{1'b0}};
        end
      end
      2'd3: begin
        tx_byte_s = fun_ext_s;
      end
      default: begin
        tx_byte_s = {BusWidth{1'b0}};
      end
    endcase
  end

  // Response byte capture and result packing, including the byte landing this cycle.
  always_comb begin
    byte0_next_s = byte0_r;
    byte1_next_s = byte1_r;
    if (capture_s) begin
      if (rx_cnt_r == 1'b0) begin
        byte0_next_s = bus.RX_P_Data;
      end else begin
        byte1_next_s = bus.RX_P_Data;
      end
    end else begin
      byte0_next_s = byte0_r;
    end
    case (type_r)
      CMD_RF_WR: rsp_data_s = {(2*BusWidth){1'b0}};
      CMD_RF_RD: rsp_data_s = {{BusWidth{1'b0}}, byte0_next_s};
      default:   rsp_data_s = {byte1_next_s, byte0_next_s};
    endcase
  end

  // Command latch, byte/response counters and response byte storage.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      type_r    <= CMD_RF_WR;
      addr_r    <= {AddWidth{1'b0}};
      opa_r     <= {BusWidth{1'b0}};
      opb_r     <= {BusWidth{1'b0}};
      fun_r     <= {FuncWidth{1'b0}};
      tx_idx_r  <= 2'd0;
      rx_cnt_r  <= 1'b0;
      byte0_r   <= {BusWidth{1'b0}};
      byte1_r   <= {BusWidth{1'b0}};
      rx_prev_r <= 1'b0;
      tmo_r     <= {TimeoutWidth{1'b0}};
    end else begin
      rx_prev_r <= bus.RX_D_VLD;
      if (accept_s) begin
        type_r   <= cmd_type_e'(bus.Cmd_Type);
        addr_r   <= bus.Cmd_Addr;
        opa_r    <= bus.Cmd_OpA;
        opb_r    <= bus.Cmd_OpB;
        fun_r    <= bus.Cmd_Fun;
        tx_idx_r <= 2'd0;
        rx_cnt_r <= 1'b0;
        byte0_r  <= {BusWidth{1'b0}};
        byte1_r  <= {BusWidth{1'b0}};
      end else begin
        if (tx_inc_s) begin
          tx_idx_r <= tx_idx_r + 2'd1;
        end
        if (capture_s) begin
          rx_cnt_r <= rx_cnt_r + 1'b1;
        end
        byte0_r <= byte0_next_s;
        byte1_r <= byte1_next_s;
      end
      if (tmo_clr_s) begin
        tmo_r <= {TimeoutWidth{1'b0}};
      end else if ((state_r == ST_RECV) && (tmo_r != TMO_MAX)) begin
        tmo_r <= tmo_r + TimeoutWidth'(1);
      end
    end
  end

  // Registered outputs: handshake, byte strobe and completion result.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cmd_ready_r <= 1'b1;
      tx_vld_r    <= 1'b0;
      tx_data_r   <= {BusWidth{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {(2*BusWidth){1'b0}};
      rsp_error_r <= 1'b0;
    end else begin
      cmd_ready_r <= (state_next_s == ST_IDLE);
      tx_vld_r    <= tx_strobe_s;
      rsp_valid_r <= (state_next_s == ST_DONE);
      if (tx_strobe_s) begin
        tx_data_r <= tx_byte_s;
      end
      if (state_next_s == ST_DONE) begin
        rsp_data_r  <= rsp_data_s;
        rsp_error_r <= tmo_err_s;
      end
    end
  end

endmodule

// File: tb/tb_host_cmd_master.sv
// Bench for host_cmd_master: directed and randomized requests against a
// frame/response model, with a busy-driven transmitter and a response monitor.
module tb_host_cmd_master;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  host_cmd_master_if #(.BusWidth(8), .AddWidth(4), .FuncWidth(4)) bus ();

  host_cmd_master #(
    .BusWidth(8), .AddWidth(4), .FuncWidth(4), .TimeoutWidth(4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: each strobe makes TX_Busy high for busy_len cycles.
  int         busy_len = 3;
  bit         busy_active = 1'b0;
  int         last_fall_cyc = 0;
  logic [7:0] tx_q[$];
  int         strobe_cyc[$];

  initial begin : busy_model
    bus.TX_Busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (bus.TX_D_VLD === 1'b1) begin
        tx_q.push_back(bus.TX_P_Data);
        strobe_cyc.push_back(cyc);
        bus.TX_Busy = 1'b1;
        busy_active = 1'b1;
        for (int i = 0; i < busy_len; i++) begin
          @(negedge CLK);
          chk("no_strobe_while_busy", {31'd0, bus.TX_D_VLD}, 32'd0);
        end
        bus.TX_Busy = 1'b0;
        busy_active = 1'b0;
        last_fall_cyc = cyc;
      end
    end
  end

  // Response monitor.
  int          rsp_count = 0;
  logic [15:0] rsp_data = 16'h0;
  logic        rsp_err = 1'b0;
  int          rsp_cyc = 0;
  logic        prev_rsp = 1'b0;

  initial begin : rsp_monitor
    forever begin
      @(negedge CLK);
      if (bus.Rsp_Valid === 1'b1) begin
        chk("rsp_single_cycle", {31'd0, prev_rsp}, 32'd0);
        rsp_count++;
        rsp_data = bus.Rsp_Data;
        rsp_err  = bus.Rsp_Error;
        rsp_cyc  = cyc;
      end
      prev_rsp = bus.Rsp_Valid;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, bus.Cmd_Ready}, 32'd1);
    chk({tag, "_tx_vld"},    {31'd0, bus.TX_D_VLD},  32'd0);
    chk({tag, "_tx_data"},   {24'd0, bus.TX_P_Data}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, bus.Rsp_Valid}, 32'd0);
    chk({tag, "_rsp_data"},  {16'd0, bus.Rsp_Data},  32'd0);
    chk({tag, "_rsp_err"},   {31'd0, bus.Rsp_Error}, 32'd0);
  endtask

  task automatic issue(input int t, input logic [3:0] addr, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] f, output int acc_cyc);
    int w;
    w = 0;
    while (busy_active && w < 100) begin
      @(negedge CLK);
      w++;
    end
    @(negedge CLK);
    bus.Cmd_Valid = 1'b1;
    bus.Cmd_Type  = 2'(t);
    bus.Cmd_Addr  = addr;
    bus.Cmd_OpA   = a;
    bus.Cmd_OpB   = b;
    bus.Cmd_Fun   = f;
    chk("cmd_ready_idle", {31'd0, bus.Cmd_Ready}, 32'd1);
    @(negedge CLK);
    acc_cyc = cyc;
    // Scramble request fields: the master must use its registered copy.
    bus.Cmd_Valid = 1'b0;
    bus.Cmd_Type  = 2'($urandom_range(0, 3));
    bus.Cmd_Addr  = 4'($urandom);
    bus.Cmd_OpA   = 8'($urandom);
    bus.Cmd_OpB   = 8'($urandom);
    bus.Cmd_Fun   = 4'($urandom);
    chk("cmd_ready_after_accept", {31'd0, bus.Cmd_Ready}, 32'd0);
  endtask

  // One full request with the expected frame and result computed from the protocol rules.
  task automatic do_cmd(input int t, input logic [3:0] addr, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] f, input int blen,
                        input int n_rx, input logic [7:0] r0, input logic [7:0] r1,
                        input int hold, input int gap, input bit pre_high);
    logic [7:0]  exp_frame[$];
    logic [7:0]  got[2];
    logic [15:0] exp_data;
    logic [7:0]  rx_bytes[2];
    bit          exp_err;
    int          exp_nrx, acc_cyc, base_rsp, w, rise_cyc, exp_cyc, nsend;

    case (t)
      0:       exp_frame = '{8'hAA, {4'h0, addr}, a};
      1:       exp_frame = '{8'hBB, {4'h0, addr}};
      2:       exp_frame = '{8'hCC, a, b, {4'h0, f}};
      default: exp_frame = '{8'hDD, {4'h0, f}};
    endcase
    exp_nrx  = (t == 0) ? 0 : ((t == 1) ? 1 : 2);
    nsend    = (n_rx < exp_nrx) ? n_rx : exp_nrx;
    rx_bytes = '{r0, r1};
    got      = '{8'h00, 8'h00};
    for (int i = 0; i < nsend; i++) got[i] = rx_bytes[i];
    exp_err  = (nsend < exp_nrx);
    if (t == 0)      exp_data = 16'h0000;
    else if (t == 1) exp_data = {8'h00, got[0]};
    else             exp_data = {got[1], got[0]};

    tx_q.delete();
    strobe_cyc.delete();
    busy_len = blen;
    base_rsp = rsp_count;
    rise_cyc = 0;
    if (pre_high) bus.RX_D_VLD = 1'b1;

    issue(t, addr, a, b, f, acc_cyc);

    w = 0;
    while ((tx_q.size() < exp_frame.size() || busy_active) && w < 400) begin
      @(negedge CLK);
      w++;
    end
    chk("frame_done_in_time", {31'd0, (w < 400)}, 32'd1);
    chk("frame_len", tx_q.size(), exp_frame.size());
    for (int i = 0; i < exp_frame.size() && i < tx_q.size(); i++)
      chk($sformatf("frame_byte%0d", i), {24'd0, tx_q[i]}, {24'd0, exp_frame[i]});
    if (strobe_cyc.size() > 0)
      chk("first_strobe_latency", strobe_cyc[0], acc_cyc + 1);

    @(negedge CLK);
    bus.RX_D_VLD = 1'b0;
    for (int i = 0; i < nsend; i++) begin
      repeat (gap) @(negedge CLK);
      bus.RX_P_Data = rx_bytes[i];
      bus.RX_D_VLD  = 1'b1;
      rise_cyc      = cyc;
      repeat (hold) @(negedge CLK);
      bus.RX_D_VLD  = 1'b0;
      bus.RX_P_Data = 8'($urandom);
    end

    w = 0;
    while (rsp_count == base_rsp && w < 100) begin
      @(negedge CLK);
      w++;
    end
    chk("rsp_seen", rsp_count, base_rsp + 1);
    chk("rsp_data", {16'd0, rsp_data}, {16'd0, exp_data});
    chk("rsp_error", {31'd0, rsp_err}, {31'd0, exp_err});
    if (exp_err)     exp_cyc = last_fall_cyc + 17;
    else if (t == 0) exp_cyc = last_fall_cyc + 1;
    else             exp_cyc = rise_cyc + 1;
    chk("rsp_latency", rsp_cyc, exp_cyc);
    repeat (3) @(negedge CLK);
    chk("rsp_count_one", rsp_count, base_rsp + 1);
    chk("cmd_ready_back", {31'd0, bus.Cmd_Ready}, 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    int acc, w, base, t, nrx, full;
    bus.Cmd_Valid = 1'b0;
    bus.Cmd_Type  = 2'd0;
    bus.Cmd_Addr  = 4'h0;
    bus.Cmd_OpA   = 8'h00;
    bus.Cmd_OpB   = 8'h00;
    bus.Cmd_Fun   = 4'h0;
    bus.RX_P_Data = 8'h00;
    bus.RX_D_VLD  = 1'b0;

    #3 RST = 1'b0;
    @(negedge CLK);
    check_reset_outputs("reset");
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    do_cmd(0, 4'h5, 8'h3C, 8'h00, 4'h0, 10, 0, 8'h00, 8'h00, 1, 1, 1'b0);
    do_cmd(1, 4'h2, 8'h00, 8'h00, 4'h0, 3, 1, 8'h81, 8'h00, 1, 1, 1'b0);
    do_cmd(2, 4'h0, 8'h12, 8'h34, 4'h1, 2, 2, 8'h46, 8'h00, 1, 2, 1'b0);
    do_cmd(3, 4'h0, 8'h00, 8'h00, 4'h2, 4, 2, 8'h10, 8'h02, 3, 1, 1'b1);
    do_cmd(1, 4'h7, 8'h00, 8'h00, 4'h0, 1, 0, 8'h00, 8'h00, 1, 1, 1'b0);
    do_cmd(3, 4'h0, 8'h00, 8'h00, 4'hF, 2, 1, 8'h5A, 8'h00, 2, 1, 1'b0);

    // Reset while waiting for the transmitter to finish byte 1.
    tx_q.delete();
    strobe_cyc.delete();
    busy_len = 10;
    issue(2, 4'h3, 8'h55, 8'h66, 4'h4, acc);
    w = 0;
    while (tx_q.size() < 2 && w < 100) begin
      @(negedge CLK);
      w++;
    end
    chk("rst_reached_byte1", tx_q.size(), 2);
    repeat (3) @(negedge CLK);
    base = rsp_count;
    #2 RST = 1'b0;
    #1 check_reset_outputs("midframe_reset");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    w = 0;
    while (busy_active && w < 100) begin
      @(negedge CLK);
      w++;
    end
    repeat (4) @(negedge CLK);
    chk("no_strobe_after_reset", tx_q.size(), 2);
    chk("no_rsp_after_reset", rsp_count, base);
    do_cmd(2, 4'h0, 8'hA5, 8'h5A, 4'h3, 3, 2, 8'hEF, 8'hBE, 2, 1, 1'b0);

    for (int n = 0; n < 16; n++) begin
      t    = $urandom_range(0, 3);
      full = (t == 0) ? 0 : ((t == 1) ? 1 : 2);
      nrx  = full;
      if (t != 0 && $urandom_range(0, 4) == 0) nrx = $urandom_range(0, full - 1);
      do_cmd(t, 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
             $urandom_range(1, 6), nrx, 8'($urandom), 8'($urandom),
             $urandom_range(1, 3), $urandom_range(1, 2), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
